// File: rtl/sound_generator_pkg.sv
// Shared constants, types and helpers for the three-tone plus noise sound generator.
package sound_generator_pkg;

  localparam int unsigned TONE_W      = 10;
  localparam int unsigned ATT_W       = 4;
  localparam int unsigned AMP_W       = 6;
  localparam int unsigned MIX_W       = 8;
  localparam int unsigned LFSR_W      = 15;
  localparam int unsigned NOISE_DIV_W = 6;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h4000;

  // Noise clock divisors in channel ticks for rate codes 00, 01, 10
  localparam int unsigned NOISE_DIV_0 = 16;
  localparam int unsigned NOISE_DIV_1 = 32;
  localparam int unsigned NOISE_DIV_2 = 64;

  // Latch byte field positions
  localparam int unsigned LATCH_BIT = 7;
  localparam int unsigned CH_HI     = 6;
  localparam int unsigned CH_LO     = 5;
  localparam int unsigned TYPE_BIT  = 4;

  typedef enum logic [1:0] {
    CH_TONE0 = 2'd0,
    CH_TONE1 = 2'd1,
    CH_TONE2 = 2'd2,
    CH_NOISE = 2'd3
  } chan_e;

  typedef struct packed {
    chan_e ch;
    logic  att;
  } latch_t;

  function automatic logic [AMP_W-1:0] att_to_amp(input logic [ATT_W-1:0] att);
    logic [AMP_W-1:0] amp;
    case (att)
      4'h0:    amp = 6'd63;
      4'h1:    amp = 6'd50;
      4'h2:    amp = 6'd40;
      4'h3:    amp = 6'd32;
      4'h4:    amp = 6'd25;
      4'h5:    amp = 6'd20;
      4'h6:    amp = 6'd16;
      4'h7:    amp = 6'd13;
      4'h8:    amp = 6'd10;
      4'h9:    amp = 6'd8;
      4'hA:    amp = 6'd6;
      4'hB:    amp = 6'd5;
      4'hC:    amp = 6'd4;
      4'hD:    amp = 6'd3;
      4'hE:    amp = 6'd2;
      default: amp = 6'd0;
    endcase
    return amp;
  endfunction

  // Terminal count of the tick divider for a given rate code
  function automatic logic [NOISE_DIV_W-1:0] noise_div_last(input logic [1:0] rate);
    logic [NOISE_DIV_W-1:0] last;
    case (rate)
      2'b00:   last = NOISE_DIV_W'(NOISE_DIV_0 - 1);
      2'b01:   last = NOISE_DIV_W'(NOISE_DIV_1 - 1);
      default: last = NOISE_DIV_W'(NOISE_DIV_2 - 1);
    endcase
    return last;
  endfunction

endpackage

// File: rtl/sound_generator_if.sv
// Processor-side write bus of the sound generator.
interface sound_generator_if;
  logic       CLK_en;
  logic       nWE;
  logic [7:0] DATA;

  modport master (output CLK_en, output nWE, output DATA);
  modport slave  (input  CLK_en, input  nWE, input  DATA);
endinterface

// File: rtl/sound_tone_channel.sv
// One square-wave tone channel: 10-bit down counter that toggles the output on reload.
module sound_tone_channel
  import sound_generator_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tick_i,
  input  logic [TONE_W-1:0] tone_i,
  output logic              out_o
);

  logic [TONE_W-1:0] cnt_q, cnt_d;
  logic              out_q, out_d;

  // Tone values 0 and 1 park the output high instead of oscillating
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (tick_i) begin
      if (tone_i <= TONE_W'(1)) begin
        cnt_d = tone_i;
        out_d = 1'b1;
      end else if (cnt_q <= TONE_W'(1)) begin
        cnt_d = tone_i;
        out_d = ~out_q;
      end else begin
        cnt_d = cnt_q - TONE_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/sound_generator.sv
// Three tone channels plus optional noise, mixed and emitted as PWM.
// Noise channel is built only when SOUND_NOISE_EN is defined.
module sound_generator
  import sound_generator_pkg::*;
#(
  parameter int unsigned TONE_PRESCALE = 8,
  parameter int unsigned PWM_WIDTH     = 8
) (
  input  logic              CLK,
  input  logic              nRESET,
  sound_generator_if.slave  bus,
  output logic              PWM
);

  localparam int unsigned PS_W = (TONE_PRESCALE > 1) ? $clog2(TONE_PRESCALE) : 1;

  logic [PS_W-1:0]      ps_q, ps_d;
  logic                 tick_c;
  logic                 wr_c;
  logic [TONE_W-1:0]    tone_q [3];
  logic [TONE_W-1:0]    tone_d [3];
  logic [ATT_W-1:0]     att_q  [4];
  logic [ATT_W-1:0]     att_d  [4];
  latch_t               latch_q, latch_d;
  logic [2:0]           tone_out;
  logic                 noise_c;
  logic [MIX_W-1:0]     mix_c;
  logic [PWM_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d, sum_q, sum_d;
  logic                 pwm_q, pwm_d;

`ifdef SOUND_NOISE_EN
  logic [2:0]             nctl_q, nctl_d;
  logic                   nctl_wr_c;
  logic [NOISE_DIV_W-1:0] ndiv_q, ndiv_d;
  logic [LFSR_W-1:0]      lfsr_q, lfsr_d;
  logic                   ch2_prev_q;
  logic                   nclk_c;
`endif

  assign tick_c = bus.CLK_en && (ps_q == PS_W'(TONE_PRESCALE - 1));
  assign wr_c   = bus.CLK_en && !bus.nWE;

  always_comb begin
    ps_d = ps_q;
    if (bus.CLK_en) ps_d = tick_c ? '0 : ps_q + PS_W'(1);
  end

  // Register file write decode; a data byte reuses the current latch
  always_comb begin
    tone_d  = tone_q;
    att_d   = att_q;
    latch_d = latch_q;
`ifdef SOUND_NOISE_EN
    nctl_d    = nctl_q;
    nctl_wr_c = 1'b0;
`endif
    if (wr_c) begin
      if (bus.DATA[LATCH_BIT]) begin
        latch_d.ch  = chan_e'(bus.DATA[CH_HI:CH_LO]);
        latch_d.att = bus.DATA[TYPE_BIT];
      end
      if (!bus.DATA[LATCH_BIT] && !latch_q.att && latch_q.ch != CH_NOISE) begin
        tone_d[2'(latch_q.ch)][TONE_W-1:4] = bus.DATA[5:0];
      end else if (latch_d.ch == CH_NOISE) begin
`ifdef SOUND_NOISE_EN
        if (latch_d.att) begin
          att_d[3] = bus.DATA[3:0];
        end else begin
          nctl_d    = bus.DATA[2:0];
          nctl_wr_c = 1'b1;
        end
`endif
      end else if (latch_d.att) begin
        att_d[2'(latch_d.ch)] = bus.DATA[3:0];
      end else begin
        tone_d[2'(latch_d.ch)][3:0] = bus.DATA[3:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      ps_q    <= '0;
      latch_q <= '{ch: CH_TONE0, att: 1'b0};
      for (int i = 0; i < 3; i++) tone_q[i] <= '0;
      for (int i = 0; i < 4; i++) att_q[i]  <= '1;
    end else begin
      ps_q    <= ps_d;
      latch_q <= latch_d;
      tone_q  <= tone_d;
      att_q   <= att_d;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_tone
    sound_tone_channel u_tone (
      .clk_i  (CLK),
      .rst_ni (nRESET),
      .tick_i (tick_c),
      .tone_i (tone_q[g]),
      .out_o  (tone_out[g])
    );
  end

`ifdef SOUND_NOISE_EN
  // Noise clock from the tick divider or from rising edges of tone channel 2
  always_comb begin
    nclk_c = 1'b0;
    ndiv_d = ndiv_q;
    lfsr_d = lfsr_q;
    if (nctl_q[1:0] == 2'b11) begin
      nclk_c = tone_out[2] && !ch2_prev_q;
    end else if (tick_c) begin
      if (ndiv_q >= noise_div_last(nctl_q[1:0])) begin
        ndiv_d = '0;
        nclk_c = 1'b1;
      end else begin
        ndiv_d = ndiv_q + NOISE_DIV_W'(1);
      end
    end
    if (nclk_c) begin
      lfsr_d = {(nctl_q[2] ? (lfsr_q[0] ^ lfsr_q[1]) : lfsr_q[0]), lfsr_q[LFSR_W-1:1]};
    end
    if (nctl_wr_c) begin
      lfsr_d = LFSR_SEED;
      ndiv_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      nctl_q     <= '0;
      ndiv_q     <= '0;
      lfsr_q     <= LFSR_SEED;
      ch2_prev_q <= 1'b0;
    end else begin
      nctl_q     <= nctl_d;
      ndiv_q     <= ndiv_d;
      lfsr_q     <= lfsr_d;
      ch2_prev_q <= tone_out[2];
    end
  end

  assign noise_c = lfsr_q[0];
`else
  assign noise_c = 1'b0;
`endif

  always_comb begin
    mix_c = '0;
    for (int i = 0; i < 4; i++) begin
      if ((i == 3) ? noise_c : tone_out[i]) mix_c = mix_c + MIX_W'(att_to_amp(att_q[i]));
    end
  end

  // Mixer sum is sampled only at counter wrap so each PWM period is stable
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_WIDTH'(1);
    sum_d     = (&pwm_cnt_q) ? PWM_WIDTH'(mix_c) : sum_q;
    pwm_d     = (pwm_cnt_q < sum_q);
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      pwm_cnt_q <= '0;
      sum_q     <= '0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      sum_q     <= sum_d;
      pwm_q     <= pwm_d;
    end
  end

  assign PWM = pwm_q;

endmodule

// File: tb/tb_sound_generator.sv
// Scoreboard bench: stimulus queues the expected high-cycle count of each 256-cycle PWM period.
module tb_sound_generator;

  logic clk = 1'b0;
  logic rst_n;
  logic pwm;

  sound_generator_if bus ();

  sound_generator #(
    .TONE_PRESCALE (8),
    .PWM_WIDTH     (8)
  ) dut (
    .CLK    (clk),
    .nRESET (rst_n),
    .bus    (bus),
    .PWM    (pwm)
  );

  always #5 clk = ~clk;

  // CLK_en is high on every second rising edge
  always @(negedge clk) bus.CLK_en = (bus.CLK_en === 1'b1) ? 1'b0 : 1'b1;

  int   q_exp[$];
  int   checks = 0;
  int   errors = 0;
  int   win_idx = 0;
  event win_done;

  // Monitor: one PWM period = 256 clocks, aligned to reset release
  initial begin
    int hi;
    int e;
    wait (rst_n === 1'b1);
    forever begin
      hi = 0;
      repeat (256) begin
        @(posedge clk);
        #1;
        if (pwm === 1'b1) hi++;
      end
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        checks++;
        if (hi != e) begin
          errors++;
          $display("FAIL pwm_period %0d: got %0d high cycles, expected %0d", win_idx, hi, e);
        end
      end
      win_idx++;
      -> win_done;
    end
  end

  task automatic wr(input logic [7:0] b);
    do begin
      @(posedge clk);
      #1;
    end while (bus.CLK_en !== 1'b0);
    bus.nWE  = 1'b0;
    bus.DATA = b;
    @(posedge clk);
    #1;
    bus.nWE = 1'b1;
  endtask

  task automatic expect_win(input int v, input int n);
    repeat (n) q_exp.push_back(v);
  endtask

  task automatic wait_win(input int n);
    repeat (n) @(win_done);
  endtask

  initial begin
    // Hold a write to attenuation 0 during reset; reset must win
    rst_n    = 1'b0;
    bus.nWE  = 1'b0;
    bus.DATA = 8'h90;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (pwm !== 1'b0) begin
      errors++;
      $display("FAIL reset_pwm: got %b, expected 0", pwm);
    end
    bus.nWE = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(win_done);

    // Idle: all attenuations F, PWM silent
    expect_win(0, 8);
    wait_win(8);

    // Tone 0 = 0x040: low 4 periods, high 4, low 4 (half-period 4 PWM periods)
    expect_win(0, 5); expect_win(63, 4); expect_win(0, 4);
    wr(8'h80); wr(8'h04); wr(8'h90);
    wait_win(13);

    // Mute ch0 while it is high: silent from the following period
    expect_win(63, 1); expect_win(0, 9);
    wr(8'hBF); wr(8'h9F);
    wait_win(10);

    // Tone 1 = 0x020: toggles every 2 PWM periods
    expect_win(0, 3); expect_win(63, 2); expect_win(0, 2); expect_win(63, 2);
    wr(8'hA0); wr(8'h02); wr(8'hB0);
    wait_win(9);

    // Tone 2 = 0x010: toggles every PWM period
    expect_win(0, 2); expect_win(63, 1); expect_win(0, 1); expect_win(63, 1); expect_win(0, 1);
    wr(8'hBF); wr(8'hC0); wr(8'h01); wr(8'hD0);
    wait_win(6);

    // Tone 2 = 1: output parked high
    expect_win(63, 4);
    wr(8'hC1); wr(8'h00);
    wait_win(4);

    // White noise rate 00: bit0 first rises after 14 shifts, falls after 15
    expect_win(63, 1);
`ifdef SOUND_NOISE_EN
    expect_win(0, 14); expect_win(63, 1); expect_win(0, 3);
`else
    expect_win(0, 18);
`endif
    wr(8'hDF);
    repeat (100) @(posedge clk);
    wr(8'hE4); wr(8'hF0);
    wait_win(19);

    checks++;
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q_exp.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/sound_generator.md
SOUND_GENERATOR -- requirements
Module: sound_generator

Interface
REQ-001 SHALL have parameter TONE_PRESCALE, default 8: CLK_en pulses per channel tick (2 MHz / 8 = 250 kHz).
REQ-002 SHALL have parameter PWM_WIDTH, default 8: mixer sum and PWM counter width.
REQ-003 CLK  input  1  single system clock (pixel clock from the timing generator); all logic on rising edge.
REQ-004 nRESET  input  1  reset; synchronous and active-low.
REQ-005 CLK_en  input  1  processor-rate enable (2 MHz) from the timing generator; qualifies writes and ticks.
REQ-006 nWE  input  1  active-low write strobe, sampled only when CLK_en=1.
REQ-007 DATA  input  8  write byte.
REQ-008 PWM  output  1  pulse-width-modulated mixed audio.

Function
REQ-009 On a CLK edge with CLK_en=1 and nWE=0, SHALL accept exactly one DATA byte; nWE held low over N enables = N writes.
REQ-010 Latch byte (DATA[7]=1): DATA[6:5] selects channel (0-2 tone, 3 noise), DATA[4] selects type (0 tone/noise control, 1 attenuation), DATA[3:0] written to the low 4 bits of that register; channel/type stored as the latched register.
REQ-011 Data byte (DATA[7]=0): if the latched register is a tone register, DATA[5:0] SHALL write tone bits [9:4]; otherwise DATA[3:0] SHALL write the latched register's low bits.
REQ-012 Tone registers are 10-bit; attenuation registers 4-bit (0 = loudest, F = silent); noise control 3-bit: [2] FB (1 white, 0 periodic), [1:0] rate.
REQ-013 Any write to the noise control register SHALL reseed the LFSR to 15'h4000.
REQ-014 Prescaler SHALL emit one tick every TONE_PRESCALE CLK_en pulses.
REQ-015 Tone channel: on each tick, if counter <= 1, load counter with tone value and toggle output; else decrement; half-period = N ticks.
REQ-016 Tone value 0 or 1 SHALL hold the channel output high.
REQ-017 Noise clock source by rate: 00 = 16 ticks, 01 = 32, 10 = 64, 11 = each rising edge of tone channel 2's output.
REQ-018 On each noise clock: LFSR shifts right; new bit 14 = bit0 XOR bit1 (white) or bit0 (periodic); noise output = bit0.
REQ-019 Attenuation-to-amplitude table (6-bit), index 0..F: 63,50,40,32,25,20,16,13,10,8,6,5,4,3,2,0.
REQ-020 Channel contribution = amplitude if channel output high, else 0; mixer sum = sum of four contributions (max 252, fits 8 bits, no overflow).
REQ-021 PWM counter SHALL increment every CLK (not CLK_en), wrapping at 2^PWM_WIDTH; PWM = 1 when counter < registered mixer sum.
REQ-022 Mixer sum SHALL be registered and update only at PWM counter wrap, so a PWM period is glitch-free.

Reset
REQ-023 While nRESET=0: tone registers 0, counters 0, outputs low, attenuations F, noise control 0, LFSR 15'h4000, latched register = channel 0 tone, prescaler 0, PWM counter 0, PWM = 0.
REQ-024 Reset SHALL take priority over a simultaneous write.

Configuration
REQ-025 Macro SOUND_NOISE_EN defined: noise channel as specified.
REQ-026 Macro SOUND_NOISE_EN undefined: no LFSR or noise logic; noise register writes update the latch only; noise contribution is 0.

Structure
REQ-027 Package sound_generator_pkg SHALL hold the attenuation table, LFSR seed 15'h4000, noise rate divisors, and latch field positions.
REQ-028 One sub-module, sound_tone_channel (10-bit counter + toggle), SHALL be instantiated three times.

Verification
REQ-029 Reset, then idle 1000 CLK_en -> PWM constantly 0, all attenuations F.
REQ-030 Write 80,04 then 90 -> tone0 = 0x040; ch0 toggles every 64 ticks = 512 CLK_en; PWM duty 63/256 while ch0 high, 0 while low.
REQ-031 Write A0,02 then B0 -> tone1 = 0x020; ch1 toggles every 256 CLK_en.
REQ-032 Write C0,01 then D0 -> tone2 = 0x010, toggles every 128 CLK_en; write C1,00 then D0 -> value 1, ch2 held high, duty 63/256.
REQ-033 Write E4 then F0 -> LFSR = 4000 after write, shifts every 128 CLK_en with white feedback; PWM duty toggles between 0 and 63/256.
REQ-034 With ch0 audible, write BF and 9F -> contributions of ch1 and ch0 are 0; PWM stays 0 from the next PWM period.
